scan_addr_gen: RTL and testbench

Three-level scan counter for the systolic array input path: pixel within a row, slice (row) within a frame, channel within a tile. It is the generalised successor of the basic pixel/slice counter. Bounds are set at run time and latched on `start`; coordinates are presented through a valid/ready handshake, with row/frame markers and a completion pulse. It sits between the control sequencer and the array's input buffers and drives their read coordinates.

---
 rtl/scan_pkg.sv | 18 +
 rtl/wrap_cntr.sv | 26 ++
 rtl/scan_addr_gen.sv | 122 ++++++++++++
 tb/tb_scan_addr_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types, defaults and width helper for the scan address generator.
package scan_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_HEIGHT   = 32;
    localparam int DEF_CHANNELS = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } scan_state_e;

    // A dimension of 1 still needs a 1-bit counter.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/wrap_cntr.sv
// Bound-limited counter: wraps to 0 on an increment at the bound and reports the wrap.
module wrap_cntr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] bound,
    output logic [W-1:0] count,
    output logic         at_bound,
    output logic         wrap
);

    assign at_bound = (count == bound);
    assign wrap     = inc && at_bound;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= at_bound ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/scan_addr_gen.sv
// Three-level scan coordinate generator (pixel/slice/channel) with row/frame/scan markers.
// Define SCAN_LIN_ADDR_EN to add the incrementally maintained lin_addr output.
module scan_addr_gen
    import scan_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HEIGHT   = DEF_HEIGHT,
    parameter int CHANNELS = DEF_CHANNELS,
    localparam int PW = clog2_min1(WIDTH),
    localparam int SW = clog2_min1(HEIGHT),
    localparam int CW = clog2_min1(CHANNELS)
`ifdef SCAN_LIN_ADDR_EN
    , localparam int AW = clog2_min1(WIDTH * HEIGHT * CHANNELS)
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [PW-1:0] cfg_width_m1,
    input  logic [SW-1:0] cfg_height_m1,
    input  logic [CW-1:0] cfg_chan_m1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] pixel_cntr,
    output logic [SW-1:0] slice_cntr,
    output logic [CW-1:0] chan_cntr,
    output logic          row_last,
    output logic          frame_last,
    output logic          scan_last,
    output logic          busy,
    output logic          done,
`ifdef SCAN_LIN_ADDR_EN
    output logic [AW-1:0] lin_addr,
`endif
    output scan_state_e   state_dbg
);

    scan_state_e   state, state_nxt;
    logic [PW-1:0] w_bound;
    logic [SW-1:0] h_bound;
    logic [CW-1:0] c_bound;
    logic          launch, fire, last_fire, clr;
    logic          pix_at, pix_wrap, slc_at, slc_wrap, chn_at;

    // Handshake: a beat transfers when out_valid && out_ready at a rising edge;
    // out_valid and the coordinates hold until then, and abort cancels the beat.
    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign state_dbg = state;
    assign fire      = out_valid && out_ready && !abort;
    assign clr       = launch || abort || last_fire;

    assign row_last   = out_valid && pix_at;
    assign frame_last = out_valid && pix_at && slc_at;
    assign scan_last  = out_valid && pix_at && slc_at && chn_at;

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = RUN;
                    launch    = 1'b1;
                end
            end
            RUN: begin
                if (abort || last_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            done    <= 1'b0;
            w_bound <= '0;
            h_bound <= '0;
            c_bound <= '0;
        end else begin
            state <= state_nxt;
            done  <= last_fire;
            if (launch) begin
                // Out-of-range bounds clamp to the largest supported index.
                w_bound <= (32'(cfg_width_m1) >= WIDTH) ? PW'(WIDTH - 1) : cfg_width_m1;
                h_bound <= (32'(cfg_height_m1) >= HEIGHT) ? SW'(HEIGHT - 1) : cfg_height_m1;
                c_bound <= (32'(cfg_chan_m1) >= CHANNELS) ? CW'(CHANNELS - 1) : cfg_chan_m1;
            end
        end
    end

    wrap_cntr #(.W(PW)) u_pixel (
        .clk(clk), .rst(rst), .clr(clr), .inc(fire), .bound(w_bound),
        .count(pixel_cntr), .at_bound(pix_at), .wrap(pix_wrap)
    );

    wrap_cntr #(.W(SW)) u_slice (
        .clk(clk), .rst(rst), .clr(clr), .inc(pix_wrap), .bound(h_bound),
        .count(slice_cntr), .at_bound(slc_at), .wrap(slc_wrap)
    );

    // The channel wrap is exactly the acceptance of the final beat.
    wrap_cntr #(.W(CW)) u_chan (
        .clk(clk), .rst(rst), .clr(clr), .inc(slc_wrap), .bound(c_bound),
        .count(chan_cntr), .at_bound(chn_at), .wrap(last_fire)
    );

`ifdef SCAN_LIN_ADDR_EN
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lin_addr <= '0;
        end else if (fire) begin
            lin_addr <= lin_addr + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_scan_addr_gen.sv
// Bench for scan_addr_gen: vector table, randomized scans against a nested-loop model, corner sequences.
module tb_scan_addr_gen;
    import scan_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, abort, out_ready;
    logic [4:0]  cfg_width_m1, cfg_height_m1;
    logic [1:0]  cfg_chan_m1;
    logic        out_valid, row_last, frame_last, scan_last, busy, done;
    logic [4:0]  pixel_cntr, slice_cntr;
    logic [1:0]  chan_cntr;
    scan_state_e st;
`ifdef SCAN_LIN_ADDR_EN
    logic [11:0] lin_addr;
`endif

    // Small instance with non-power-of-two bounds for the clamping check.
    logic        s_start, s_valid, s_row_last, s_frame_last, s_scan_last, s_busy, s_done;
    logic        s_abort = 1'b0;
    logic        s_ready = 1'b1;
    logic [2:0]  s_cfg_w, s_pixel;
    logic [1:0]  s_cfg_h, s_slice;
    logic [0:0]  s_cfg_c, s_chan;
    scan_state_e s_st;
`ifdef SCAN_LIN_ADDR_EN
    logic [4:0]  s_lin;
`endif

    int total = 0;
    int bad   = 0;
    logic [14:0] exp_q[$];

    always #5 clk = ~clk;

    scan_addr_gen dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_width_m1(cfg_width_m1), .cfg_height_m1(cfg_height_m1), .cfg_chan_m1(cfg_chan_m1),
        .out_valid(out_valid), .out_ready(out_ready),
        .pixel_cntr(pixel_cntr), .slice_cntr(slice_cntr), .chan_cntr(chan_cntr),
        .row_last(row_last), .frame_last(frame_last), .scan_last(scan_last),
        .busy(busy), .done(done),
`ifdef SCAN_LIN_ADDR_EN
        .lin_addr(lin_addr),
`endif
        .state_dbg(st)
    );

    scan_addr_gen #(.WIDTH(5), .HEIGHT(3), .CHANNELS(2)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
        .cfg_width_m1(s_cfg_w), .cfg_height_m1(s_cfg_h), .cfg_chan_m1(s_cfg_c),
        .out_valid(s_valid), .out_ready(s_ready),
        .pixel_cntr(s_pixel), .slice_cntr(s_slice), .chan_cntr(s_chan),
        .row_last(s_row_last), .frame_last(s_frame_last), .scan_last(s_scan_last),
        .busy(s_busy), .done(s_done),
`ifdef SCAN_LIN_ADDR_EN
        .lin_addr(s_lin),
`endif
        .state_dbg(s_st)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: every beat of the scan in order, with its markers, from nested loops.
    task automatic build_model(input int w, input int h, input int c);
        exp_q.delete();
        for (int ci = 0; ci <= c; ci++)
            for (int si = 0; si <= h; si++)
                for (int pi = 0; pi <= w; pi++)
                    exp_q.push_back({ci[1:0], si[4:0], pi[4:0], pi == w,
                                     (pi == w) && (si == h), (pi == w) && (si == h) && (ci == c)});
    endtask

    task automatic run_scan(input int w, input int h, input int c, input int mode,
                            input int abort_at, input bit hold_start,
                            output int beats, output int cycles);
        logic [14:0] e;
        bit aborted;
        aborted = 1'b0;
        beats   = 0;
        cycles  = 0;
        build_model(w, h, c);
        cfg_width_m1  = w[4:0];
        cfg_height_m1 = h[4:0];
        cfg_chan_m1   = c[1:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = hold_start;
        while (exp_q.size() > 0 && cycles < 20000) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = cycles[0];
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            abort = (beats == abort_at);
            if (mode == 2) begin
                cfg_width_m1  = 5'($urandom_range(0, 31));
                cfg_height_m1 = 5'($urandom_range(0, 31));
                cfg_chan_m1   = 2'($urandom_range(0, 3));
                start         = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            e = exp_q[0];
            chk("out_valid", out_valid, 1);
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            chk("chan", chan_cntr, e[14:13]);
            chk("slice", slice_cntr, e[12:8]);
            chk("pixel", pixel_cntr, e[7:3]);
            chk("row_last", row_last, e[2]);
            chk("frame_last", frame_last, e[1]);
            chk("scan_last", scan_last, e[0]);
`ifdef SCAN_LIN_ADDR_EN
            chk("lin_addr", lin_addr, e[7:3] + e[12:8] * (w + 1) + e[14:13] * (w + 1) * (h + 1));
`endif
            if (abort) begin
                @(posedge clk); #1;
                abort = 1'b0;
                out_ready = 1'b0;
                start = 1'b0;
                @(negedge clk);
                chk("abort_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_coords", {chan_cntr, slice_cntr, pixel_cntr}, 0);
                chk("abort_done", done, 0);
                @(posedge clk); #1;
                @(negedge clk);
                chk("abort_no_done", done, 0);
                aborted = 1'b1;
                exp_q.delete();
            end else begin
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
                @(posedge clk); #1;
                cycles++;
            end
        end
        if (!aborted) begin
            if (exp_q.size() > 0) chk("scan_timeout", exp_q.size(), 0);
            start = hold_start;
            abort = 1'b0;
            out_ready = 1'b0;
            @(negedge clk);
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 0);
            chk("done_valid", out_valid, 0);
            chk("done_coords", {chan_cntr, slice_cntr, pixel_cntr}, 0);
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("next_valid", out_valid, hold_start);
        end
    endtask

    typedef struct {
        int w, h, c, mode, abort_at, beats, cycles;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int beats, cycles, w, h, c, n, maxp, maxs, rows;
        bit seen_done;

        tbl[0] = '{3, 1, 0, 0, -1, 8, 8};
        tbl[1] = '{1, 1, 1, 1, -1, 8, 16};
        tbl[2] = '{3, 3, 0, 0, 4, 4, 0};
        tbl[3] = '{0, 0, 0, 0, -1, 1, 1};
        tbl[4] = '{31, 1, 3, 2, -1, 256, 0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        cfg_width_m1 = '0; cfg_height_m1 = '0; cfg_chan_m1 = '0;
        s_start = 1'b0; s_cfg_w = 3'd7; s_cfg_h = 2'd3; s_cfg_c = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_coords", {chan_cntr, slice_cntr, pixel_cntr}, 0);
        chk("rst_markers", {row_last, frame_last, scan_last}, 0);
        chk("rst_state", st, IDLE);
`ifdef SCAN_LIN_ADDR_EN
        chk("rst_lin", lin_addr, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_with_abort", out_valid, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run_scan(tbl[i].w, tbl[i].h, tbl[i].c, tbl[i].mode, tbl[i].abort_at, 1'b0, beats, cycles);
            chk("vec_beats", beats, tbl[i].beats);
            if (tbl[i].cycles != 0) chk("vec_cycles", cycles, tbl[i].cycles);
            @(posedge clk); #1;
        end

        repeat (6) begin
            w = $urandom_range(0, 7);
            h = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            run_scan(w, h, c, 2, -1, 1'b0, beats, cycles);
            chk("rand_beats", beats, (w + 1) * (h + 1) * (c + 1));
            @(posedge clk); #1;
        end

        // Back-to-back launch, then synchronous reset in the middle of the new scan.
        run_scan(1, 0, 0, 0, -1, 1'b1, beats, cycles);
        chk("b2b_coords", {chan_cntr, slice_cntr, pixel_cntr}, 0);
        chk("b2b_done", done, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_pixel", pixel_cntr, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pixel", pixel_cntr, 0);
        chk("midrst_done", done, 0);
        chk("midrst_markers", {row_last, frame_last, scan_last}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Width 7 > 4 and height 3 > 2 must clamp: 5 x 3 x 2 = 30 beats.
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        n = 0; maxp = 0; maxs = 0; rows = 0; seen_done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_done) begin
                seen_done = 1'b1;
                break;
            end
            if (s_valid) begin
`ifdef SCAN_LIN_ADDR_EN
                chk("small_lin", s_lin, n);
`endif
                n++;
                if (int'(s_pixel) > maxp) maxp = int'(s_pixel);
                if (int'(s_slice) > maxs) maxs = int'(s_slice);
                if (s_row_last) rows++;
            end
        end
        chk("clamp_done_seen", seen_done, 1);
        chk("clamp_beats", n, 30);
        chk("clamp_max_pixel", maxp, 4);
        chk("clamp_max_slice", maxs, 2);
        chk("clamp_rows", rows, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
